// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/wait controller for the 5-stage pipeline: load-use stalls, taken-branch
// squash, multi-cycle data-memory waits with a watchdog that parks the core in HALT.
module pipe_hazard_ctrl #(
    parameter int unsigned STALL_MAX = 15,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_ex_load,
    input  logic [4:0]       i_ex_wa,
    input  logic             i_br_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    output logic             o_pc_we,
    output logic             o_fi_id_pause,
    output logic             o_id_ex_pause,
    output logic             o_ex_mem_pause,
    output logic             o_mem_wb_pause,
    output logic             o_mem_err,
    output logic [1:0]       o_ctrl_state,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } state_e;

    localparam logic [7:0] WaitMax = 8'(STALL_MAX);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             r_mem_err;
    logic             w_mem_err_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;

    // Branch/load-use response, shared by RUN and the ack cycle of MEM_WAIT
    logic w_hz_pc_we;
    logic w_hz_fi_id_pause;
    logic w_hz_id_ex_pause;

    logic w_pc_we;
    logic w_fi_id_pause;
    logic w_id_ex_pause;
    logic w_ex_mem_pause;
    logic w_mem_wb_pause;

    always_comb begin
        w_rs_hit   = i_id_use_rs && (i_id_rs == i_ex_wa);
        w_rt_hit   = i_id_use_rt && (i_id_rt == i_ex_wa);
        w_load_use = i_ex_load && (i_ex_wa != 5'd0) && (w_rs_hit || w_rt_hit);
    end

    // Branch beats load-use: the dependent instruction is squashed, so no stall is needed
    always_comb begin
        w_hz_pc_we       = 1'b1;
        w_hz_fi_id_pause = 1'b0;
        w_hz_id_ex_pause = 1'b0;
        if (i_br_taken) begin
            w_hz_fi_id_pause = 1'b1;
            w_hz_id_ex_pause = 1'b1;
        end else if (w_load_use) begin
            w_hz_pc_we       = 1'b0;
            w_hz_fi_id_pause = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        w_pc_we        = 1'b1;
        w_fi_id_pause  = 1'b0;
        w_id_ex_pause  = 1'b0;
        w_ex_mem_pause = 1'b0;
        w_mem_wb_pause = 1'b0;

        unique case (r_state)
            StRun: begin
                if (i_mem_req && !i_mem_ack) begin
                    w_pc_we        = 1'b0;
                    w_fi_id_pause  = 1'b1;
                    w_id_ex_pause  = 1'b1;
                    w_ex_mem_pause = 1'b1;
                    w_mem_wb_pause = 1'b1;
                    w_state_nxt    = StMemWait;
                    w_wait_cnt_nxt = 8'd1;
                end else begin
                    w_pc_we       = w_hz_pc_we;
                    w_fi_id_pause = w_hz_fi_id_pause;
                    w_id_ex_pause = w_hz_id_ex_pause;
                end
            end
            StMemWait: begin
                if (i_mem_ack) begin
                    w_pc_we        = w_hz_pc_we;
                    w_fi_id_pause  = w_hz_fi_id_pause;
                    w_id_ex_pause  = w_hz_id_ex_pause;
                    w_state_nxt    = StRun;
                    w_wait_cnt_nxt = 8'd0;
                end else begin
                    w_pc_we        = 1'b0;
                    w_fi_id_pause  = 1'b1;
                    w_id_ex_pause  = 1'b1;
                    w_ex_mem_pause = 1'b1;
                    w_mem_wb_pause = 1'b1;
                    if (r_wait_cnt < WaitMax) begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end else begin
                        w_state_nxt   = StHalt;
                        w_mem_err_nxt = 1'b1;
                    end
                end
            end
            StHalt: begin
                w_pc_we        = 1'b0;
                w_fi_id_pause  = 1'b1;
                w_id_ex_pause  = 1'b1;
                w_ex_mem_pause = 1'b1;
                w_mem_wb_pause = 1'b1;
                w_mem_err_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt    = StRun;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase

        // Reset forces the default output set so nothing is paused while it is held
        if (i_rst) begin
            w_pc_we        = 1'b1;
            w_fi_id_pause  = 1'b0;
            w_id_ex_pause  = 1'b0;
            w_ex_mem_pause = 1'b0;
            w_mem_wb_pause = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StRun;
            r_wait_cnt     <= 8'd0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
            if (!w_pc_we && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_pc_we        = w_pc_we;
        o_fi_id_pause  = w_fi_id_pause;
        o_id_ex_pause  = w_id_ex_pause;
        o_ex_mem_pause = w_ex_mem_pause;
        o_mem_wb_pause = w_mem_wb_pause;
        o_mem_err      = r_mem_err;
        o_ctrl_state   = i_rst ? 2'd0 : r_state;
        o_stall_cycles = r_stall_cycles;
    end

endmodule
